// File: rtl/mux_pkg.sv
// Shared constants and elaboration helpers for the N-channel arbitrated mux.
package mux_pkg;

    localparam int MAX_NCH   = 8;
    localparam int MAX_WIDTH = 64;

    // Ceiling log2, usable in parameter expressions; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter with a last-granted pointer. In round-robin mode the search
// starts just above the pointer and wraps; in fixed mode the search base is
// pinned to the top channel, so the lowest requesting index always wins.
module rr_arbiter #(
    parameter int NCH  = 2,
    parameter int SELW = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req_i,
    input  logic            rr_mode_i,
    input  logic            advance_i,
    output logic [NCH-1:0]  grant_o,
    output logic [SELW-1:0] grant_idx_o
);

    logic [SELW-1:0] last_q;
    logic [SELW-1:0] last_d;
    logic [NCH-1:0]  upper;
    logic [NCH-1:0]  pick;
    int              base;

    // Prefer requesters above the base; if none, wrap to the full request set,
    // then take the lowest set bit of whichever set was chosen.
    always_comb begin
        // NOTE: every output of a combinational block gets a default up front so no path leaves it unassigned (which would infer a latch).
        grant_o     = '0;
        grant_idx_o = '0;
        base        = rr_mode_i ? int'(last_q) : NCH - 1;
        for (int i = 0; i < NCH; i++) begin
            upper[i] = (i > base);
        end
        pick = (|(req_i & upper)) ? (req_i & upper) : req_i;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant_o     = '0;
                grant_o[i]  = 1'b1;
                grant_idx_o = SELW'(i);
            end
        end
    end

    // Pointer moves to the granted channel only when a transfer is strobed.
    always_comb begin
        last_d = last_q;
        if (advance_i) begin
            last_d = grant_idx_o;
        end
    end

    // Pointer register; resetting to the top channel gives channel 0 first turn.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            last_q <= SELW'(NCH - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel valid/ready mux: arbitrates among valid inputs, optionally forced
// to one channel, and registers the selected word with its source index.
module mux_arb_n
    import mux_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  NCH   = 2,
    parameter int  RR    = 1,
    localparam int SELW  = (clog2(NCH) > 1) ? clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 force_en,
    input  logic [SELW-1:0]      force_sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    if (NCH < 2 || NCH > MAX_NCH || WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_params
        $error("mux_arb_n: WIDTH or NCH outside supported range");
    end

    logic             load_en;
    logic             transfer;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] sel_data;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;

    // The output register can take a word when empty or being drained.
    assign load_en = !out_valid_q || out_ready;

    // Forcing narrows the request set to one channel; an index beyond NCH
    // matches nothing, so nothing is granted.
    always_comb begin
        req = in_valid;
        if (force_en) begin
            req = '0;
            for (int i = 0; i < NCH; i++) begin
                if (force_sel == SELW'(i)) begin
                    req[i] = in_valid[i];
                end
            end
        end
    end

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .rr_mode_i   (RR != 0),
        .advance_i   (transfer && !force_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign in_ready = grant & {NCH{load_en && !rst}};
    assign transfer = |(in_valid & in_ready);

    // AND-OR select gated by grant so data on other channels cannot leak in.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Load on transfer, empty on drain without refill, otherwise hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (transfer) begin
            out_data_d  = sel_data;
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register; a reset discards any held word.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the data register is reset only because a defined zero must be visible after reset; pure datapath storage would normally skip it.
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
